// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle RISC-V control path: opcodes,
// datapath select codes and sequencer state encodings.
package multicycle_control_pkg;

    // Major opcodes, instr[6:0]
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] TIPOR  = 7'b0110011;
    localparam logic [6:0] TIPOU  = 7'b0110111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JUMP   = 7'b1101111;

    // Register write-back source
    localparam logic [1:0] ORIG_ALU = 2'd0;
    localparam logic [1:0] ORIG_MEM = 2'd1;
    localparam logic [1:0] ORIG_PC4 = 2'd2;
    localparam logic [1:0] ORIG_LUI = 2'd3;

    // Next-PC source
    localparam logic [1:0] PC4   = 2'd0;
    localparam logic [1:0] PCBEQ = 2'd1;
    localparam logic [1:0] PCIMM = 2'd2;

    // ALU operation class
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_ANY = 2'd2;

    // ALU second operand
    localparam logic ORIG_REG = 1'b0;
    localparam logic ORIG_IMM = 1'b1;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    // True for opcodes the sequencer knows how to execute
    function automatic logic isLegalOp(input logic [6:0] op);
        case (op)
            LOAD, STORE, TIPOR, TIPOU, BRANCH, JUMP: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_watchdog.sv
// Memory-wait watchdog: counts consecutive cycles spent waiting for
// mem_ready and flags a timeout on the last allowed waiting cycle.
module multicycle_control_watchdog #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic timeout
);
    localparam int W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

    logic [W-1:0] waitCnt;

    // Wait counter: restarts whenever the access completes or no access is pending
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            waitCnt <= '0;
        end else if (enable) begin
            waitCnt <= waitCnt + W'(1);
        end
    end

    // A ready arriving on the last cycle suppresses the timeout because enable is then low
    assign timeout = enable && (waitCnt == LAST);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB over a shared memory with
// a ready handshake, producing Moore-style datapath selects and enables.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic [1:0]       OrigWriteData,
    output logic [1:0]       OrigPC,
    output logic [1:0]       ALUOp,
    output logic             OrigALU,
    output logic             trap,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] retired
);

    state_t     stateQ, stateD;
    logic [6:0] opQ;
    logic       memWait;
    logic       timeout;
    logic       retire;

    // Only FETCH and MEM ever wait on memory; elsewhere mem_ready is ignored
    assign memWait = ((stateQ == S_FETCH) || (stateQ == S_MEM)) && !mem_ready;

    multicycle_control_watchdog #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) uWatchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (!memWait),
        .enable (memWait),
        .timeout(timeout)
    );

    // State, latched opcode and retired counter
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ  <= S_FETCH;
            opQ     <= '0;
            retired <= '0;
        end else begin
            stateQ <= stateD;
            if (stateQ == S_DECODE) begin
                opQ <= opcode;
            end
            if (retire) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    // Next-state and output decode; reset forces every enable and select to 0
    always_comb begin
        stateD        = stateQ;
        IRWrite       = 1'b0;
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        RegWrite      = 1'b0;
        OrigWriteData = ORIG_ALU;
        OrigPC        = PC4;
        ALUOp         = OP_ADD;
        OrigALU       = ORIG_IMM;

        case (stateQ)
            S_FETCH: begin
                MemRead = 1'b1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    stateD  = S_DECODE;
                end else if (timeout) begin
                    stateD = S_TRAP;
                end
            end
            S_DECODE: begin
                // The opcode is taken straight from the IR here; opQ is valid from EXEC on
                stateD = isLegalOp(opcode) ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                case (opQ)
                    TIPOR: begin
                        OrigALU = ORIG_REG;
                        ALUOp   = OP_ANY;
                        stateD  = S_WB;
                    end
                    TIPOU: stateD = S_WB;
                    LOAD, STORE: stateD = S_MEM;
                    BRANCH: begin
                        ALUOp       = OP_SUB;
                        OrigALU     = ORIG_REG;
                        OrigPC      = PCBEQ;
                        PCWriteCond = 1'b1;
                        stateD      = S_FETCH;
                    end
                    JUMP: begin
                        RegWrite      = 1'b1;
                        OrigWriteData = ORIG_PC4;
                        OrigPC        = PCIMM;
                        PCWrite       = 1'b1;
                        stateD        = S_FETCH;
                    end
                    default: stateD = S_TRAP;
                endcase
            end
            S_MEM: begin
                IorD     = 1'b1;
                MemRead  = (opQ == LOAD);
                MemWrite = (opQ == STORE);
                if (mem_ready) begin
                    if (opQ == STORE) begin
                        PCWrite = 1'b1;
                        stateD  = S_FETCH;
                    end else begin
                        stateD = S_WB;
                    end
                end else if (timeout) begin
                    stateD = S_TRAP;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                if (opQ == LOAD) begin
                    OrigWriteData = ORIG_MEM;
                end else if (opQ == TIPOU) begin
                    OrigWriteData = ORIG_LUI;
                end
                stateD = S_FETCH;
            end
            default: stateD = S_TRAP;
        endcase

        if (reset) begin
            IRWrite       = 1'b0;
            PCWrite       = 1'b0;
            PCWriteCond   = 1'b0;
            IorD          = 1'b0;
            MemRead       = 1'b0;
            MemWrite      = 1'b0;
            RegWrite      = 1'b0;
            OrigWriteData = 2'd0;
            OrigPC        = 2'd0;
            ALUOp         = 2'd0;
            OrigALU       = 1'b0;
        end
    end

    // An instruction retires when EXEC, MEM or WB hands control back to FETCH
    assign retire = !reset && (stateD == S_FETCH) &&
                    ((stateQ == S_EXEC) || (stateQ == S_MEM) || (stateQ == S_WB));

    assign trap    = (stateQ == S_TRAP);
    assign state_o = stateQ;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle expected output
// vectors are queued as stimulus is driven and compared at the falling edge.
module tb_multicycle_control;

    localparam int CNT_W = 32;

    // Encodings written out independently of the design package
    localparam logic [6:0] OPC_LW  = 7'h03;
    localparam logic [6:0] OPC_SW  = 7'h23;
    localparam logic [6:0] OPC_R   = 7'h33;
    localparam logic [6:0] OPC_BEQ = 7'h63;
    localparam logic [6:0] OPC_JAL = 7'h6F;
    localparam logic [6:0] OPC_BAD = 7'h7F;

    localparam logic [2:0] ST_F = 3'd0, ST_D = 3'd1, ST_E = 3'd2,
                           ST_M = 3'd3, ST_W = 3'd4, ST_T = 3'd5;

    // Enable groups: {IRWrite,PCWrite,PCWriteCond,IorD,MemRead,MemWrite,RegWrite}
    localparam logic [6:0] EN_NONE   = 7'b0000000;
    localparam logic [6:0] EN_FWAIT  = 7'b0000100;
    localparam logic [6:0] EN_FRDY   = 7'b1000100;
    localparam logic [6:0] EN_LDMEM  = 7'b0001100;
    localparam logic [6:0] EN_STMEM  = 7'b0001010;
    localparam logic [6:0] EN_STDONE = 7'b0101010;
    localparam logic [6:0] EN_WB     = 7'b0100001;
    localparam logic [6:0] EN_BR     = 7'b0010000;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [6:0]       opcode = '0;
    logic             mem_ready = 1'b0;
    logic             IRWrite, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, RegWrite;
    logic [1:0]       OrigWriteData, OrigPC, ALUOp;
    logic             OrigALU, trap;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] retired;

    typedef struct {
        string       tag;
        logic [17:0] vec;
    } exp_t;

    exp_t expQ[$];
    int   nChecks = 0;
    int   nPass   = 0;

    multicycle_control #(
        .MEM_TIMEOUT(4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .IRWrite      (IRWrite),
        .PCWrite      (PCWrite),
        .PCWriteCond  (PCWriteCond),
        .IorD         (IorD),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .RegWrite     (RegWrite),
        .OrigWriteData(OrigWriteData),
        .OrigPC       (OrigPC),
        .ALUOp        (ALUOp),
        .OrigALU      (OrigALU),
        .trap         (trap),
        .state_o      (state_o),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected output vector: {enables, OrigWriteData, OrigPC, ALUOp, OrigALU, trap, state}
    function automatic logic [17:0] ev(input logic [6:0] en, input logic [1:0] owd,
                                       input logic [1:0] opc, input logic [1:0] alu,
                                       input logic oalu, input logic trp, input logic [2:0] st);
        return {en, owd, opc, alu, oalu, trp, st};
    endfunction

    // Default selects outside reset: PC4, OP_ADD, ORIG_IMM, ORIG_ALU
    function automatic logic [17:0] evd(input logic [6:0] en, input logic trp, input logic [2:0] st);
        return ev(en, 2'd0, 2'd0, 2'd0, 1'b1, trp, st);
    endfunction

    // One clock: drive inputs, queue the expectation, compare at the falling edge
    task automatic cycle(input string tag, input logic rst, input logic rdy,
                         input logic [6:0] op, input logic [17:0] expVec);
        exp_t e;
        logic [17:0] got;
        reset     = rst;
        mem_ready = rdy;
        opcode    = op;
        expQ.push_back('{tag, expVec});
        @(negedge clk);
        got = {IRWrite, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, RegWrite,
               OrigWriteData, OrigPC, ALUOp, OrigALU, trap, state_o};
        if (expQ.size() == 0) begin
            checkVal({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = expQ.pop_front();
            checkVal(e.tag, {14'd0, got}, {14'd0, e.vec});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        // Power-up: state is unknown during the first reset cycle, so only clock it
        reset = 1'b1;
        @(posedge clk);
        #1;
        cycle("reset", 1'b1, 1'b0, 7'h00, ev(EN_NONE, 0, 0, 0, 0, 0, ST_F));
        checkVal("reset_retired", retired, 32'd0);

        // 1: add x3,x1,x2 with zero-wait memory
        cycle("add_fetch",  0, 1, OPC_R, evd(EN_FRDY, 0, ST_F));
        cycle("add_decode", 0, 1, OPC_R, evd(EN_NONE, 0, ST_D));
        cycle("add_exec",   0, 1, OPC_R, ev(EN_NONE, 2'd0, 2'd0, 2'd2, 1'b0, 0, ST_E));
        cycle("add_wb",     0, 1, OPC_R, evd(EN_WB, 0, ST_W));
        checkVal("add_retired", retired, 32'd1);

        // 2: lw with three wait cycles in MEM (ready on the last allowed cycle)
        cycle("lw_fetch",  0, 1, OPC_LW, evd(EN_FRDY, 0, ST_F));
        cycle("lw_decode", 0, 1, OPC_LW, evd(EN_NONE, 0, ST_D));
        cycle("lw_exec",   0, 1, OPC_LW, evd(EN_NONE, 0, ST_E));
        for (int i = 0; i < 3; i++) begin
            cycle($sformatf("lw_memwait%0d", i), 0, 0, OPC_LW, evd(EN_LDMEM, 0, ST_M));
        end
        cycle("lw_memrdy", 0, 1, OPC_LW, evd(EN_LDMEM, 0, ST_M));
        cycle("lw_wb",     0, 1, OPC_LW, ev(EN_WB, 2'd1, 2'd0, 2'd0, 1'b1, 0, ST_W));
        checkVal("lw_retired", retired, 32'd2);

        // 3: beq then jal
        cycle("beq_fetch",  0, 1, OPC_BEQ, evd(EN_FRDY, 0, ST_F));
        cycle("beq_decode", 0, 1, OPC_BEQ, evd(EN_NONE, 0, ST_D));
        cycle("beq_exec",   0, 1, OPC_BEQ, ev(EN_BR, 2'd0, 2'd1, 2'd1, 1'b0, 0, ST_E));
        checkVal("beq_retired", retired, 32'd3);
        cycle("jal_fetch",  0, 1, OPC_JAL, evd(EN_FRDY, 0, ST_F));
        cycle("jal_decode", 0, 1, OPC_JAL, evd(EN_NONE, 0, ST_D));
        cycle("jal_exec",   0, 1, OPC_JAL, ev(EN_WB, 2'd2, 2'd2, 2'd0, 1'b1, 0, ST_E));
        checkVal("jal_retired", retired, 32'd4);

        // 4: illegal opcode traps; trap holds through mem_ready until reset
        cycle("bad_fetch",  0, 1, OPC_BAD, evd(EN_FRDY, 0, ST_F));
        cycle("bad_decode", 0, 1, OPC_BAD, evd(EN_NONE, 0, ST_D));
        for (int i = 0; i < 3; i++) begin
            cycle($sformatf("trap_hold%0d", i), 0, 1, OPC_R, evd(EN_NONE, 1, ST_T));
        end
        checkVal("trap_retired", retired, 32'd4);
        cycle("trap_reset", 1, 1, OPC_R, ev(EN_NONE, 0, 0, 0, 0, 1, ST_T));
        checkVal("trap_reset_retired", retired, 32'd0);

        // 5a: no ready in FETCH -> trap after four waiting cycles
        for (int i = 0; i < 4; i++) begin
            cycle($sformatf("to_fwait%0d", i), 0, 0, OPC_R, evd(EN_FWAIT, 0, ST_F));
        end
        cycle("to_trap", 0, 0, OPC_R, evd(EN_NONE, 1, ST_T));
        cycle("to_reset", 1, 0, OPC_R, ev(EN_NONE, 0, 0, 0, 0, 1, ST_T));

        // 5b: ready on the fourth FETCH cycle wins over the timeout
        for (int i = 0; i < 3; i++) begin
            cycle($sformatf("late_fwait%0d", i), 0, 0, OPC_R, evd(EN_FWAIT, 0, ST_F));
        end
        cycle("late_frdy",   0, 1, OPC_R, evd(EN_FRDY, 0, ST_F));
        cycle("late_decode", 0, 1, OPC_R, evd(EN_NONE, 0, ST_D));
        cycle("late_exec",   0, 1, OPC_R, ev(EN_NONE, 2'd0, 2'd0, 2'd2, 1'b0, 0, ST_E));
        cycle("late_wb",     0, 1, OPC_R, evd(EN_WB, 0, ST_W));
        checkVal("late_retired", retired, 32'd1);

        // 6: sw waiting in MEM, reset mid-wait aborts with no PC write
        cycle("sw_fetch",  0, 1, OPC_SW, evd(EN_FRDY, 0, ST_F));
        cycle("sw_decode", 0, 1, OPC_SW, evd(EN_NONE, 0, ST_D));
        cycle("sw_exec",   0, 1, OPC_SW, evd(EN_NONE, 0, ST_E));
        cycle("sw_memwait0", 0, 0, OPC_SW, evd(EN_STMEM, 0, ST_M));
        cycle("sw_memwait1", 0, 0, OPC_SW, evd(EN_STMEM, 0, ST_M));
        cycle("sw_reset",    1, 1, OPC_SW, ev(EN_NONE, 0, 0, 0, 0, 0, ST_M));
        cycle("sw_after",    0, 0, OPC_SW, evd(EN_FWAIT, 0, ST_F));
        checkVal("sw_retired", retired, 32'd0);

        // Completed store with ready on first MEM cycle retires directly from MEM
        cycle("sw2_fetch",  0, 1, OPC_SW, evd(EN_FRDY, 0, ST_F));
        cycle("sw2_decode", 0, 1, OPC_SW, evd(EN_NONE, 0, ST_D));
        cycle("sw2_exec",   0, 1, OPC_SW, evd(EN_NONE, 0, ST_E));
        cycle("sw2_mem",    0, 1, OPC_SW, evd(EN_STDONE, 0, ST_M));
        cycle("sw2_next",   0, 0, OPC_SW, evd(EN_FWAIT, 0, ST_F));
        checkVal("sw2_retired", retired, 32'd1);

        checkVal("queue_empty", expQ.size(), 32'd0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
